uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter among `NUM_REQ` byte requesters. It latches the winning requester's byte and issues a single-cycle `tx_start`. It then holds `tx_data` stable until `tx_done` and returns a per-requester `ack`, or an `err` if the transmitter does not finish within a watchdog window. It sits between the system's message sources and the `uart_tx` instance, and both blocks share `clk` and `arstn`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: byte width; must match `uart_tx`.
- `TIMEOUT_CYCLES`, 65536: watchdog limit in clk cycles, counted from the `tx_start` pulse; must exceed one full UART frame.

- `clk` in 1: clock.
- `arstn` in 1: reset; asynchronous, active-low.
- `req` in NUM_REQ: level request per requester; held until that requester's `ack` or `err`.
- `req_data` in NUM_REQ*DATA_WIDTH: byte for requester i on bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant` out NUM_REQ: one-hot, set for the requester being serviced; zero otherwise.
- `ack` out NUM_REQ: one-cycle pulse on bit i when i's byte has been transmitted.
- `err` out NUM_REQ: one-cycle pulse on bit i when i's transfer timed out.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out DATA_WIDTH: byte to `uart_tx`; stable from the `tx_start` cycle until after `tx_done`.
- `tx_done` in 1: one-cycle completion pulse from `uart_tx`.

## Operation
- FSM states:
  - IDLE
    - If `|req`: select the winner, set `grant`, load `tx_data` from that requester's `req_data` slice, set `tx_start`=1, `busy`=1, clear the timer, and go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT
    - `tx_start`=0 after its first cycle. The timer increments every cycle.
    - If `tx_done`=1: set `ack[winner]`=1 and go to DONE.
    - Else, if timer == TIMEOUT_CYCLES-1: set `err[winner]`=1 and go to DONE.
  - DONE
    - Clear `ack`, `err`, `grant` and `busy`.
    - Set `ptr` to (winner+1) mod NUM_REQ.
    - Go to IDLE.
- Round-robin:
  - `ptr` is a clog2(NUM_REQ)-bit index with reset value 0.
  - The winner is the first i with `req[i]`=1, searching ptr, ptr+1, … with wrap at NUM_REQ-1 → 0.
  - `ptr` advances only in DONE, after both ack and err.
- All outputs are registered. Reset values: `grant`=0, `ack`=0, `err`=0, `busy`=0, `tx_start`=0, `tx_data`=0, state=IDLE, `ptr`=0, timer=0.
- `tx_data` keeps its last value after DONE and changes only on the next grant.
- Timer width is clog2(TIMEOUT_CYCLES). The timer saturates and never wraps.

## Timing
- Request to start: `req` sampled at edge E0 in IDLE → `grant`, `tx_data` and `tx_start` are valid from E0. `tx_start` is high for exactly one cycle (E0 to E1).
- `uart_tx` samples `tx_start` at E1 and captures `tx_data` up to one baud period later. `tx_data` is therefore held for the whole of WAIT.
- Completion: `tx_done` sampled at edge Ed → `ack[winner]` is high from Ed to Ed+1. DONE occupies Ed to Ed+1. The earliest next arbitration is at edge Ed+2.
- A requester that drops `req` on the edge after seeing `ack` is never re-granted spuriously.
- Back-to-back throughput: one UART frame plus 3 clk cycles per byte.
- Boundary and corner cases:
  - `tx_done` and timer == TIMEOUT_CYCLES-1 in the same cycle → `ack` is asserted, `err` is not.
  - `tx_done` outside WAIT is ignored.
  - `req`/`req_data` changes or withdrawal during WAIT or DONE are ignored. The latched transfer completes and still produces `ack`/`err`.
  - Exactly one of `ack`/`err` pulses per grant. `ack|err` is never multi-hot.
  - With a single requester active continuously, it is granted every service slot.
  - `arstn` low in any state: all outputs go to their reset values immediately. The in-flight transfer is dropped, with no `ack`/`err`. On release, the block starts in IDLE with `ptr`=0.

## Test plan
- Single request: `req`=0100, slice 2 = 0xA5 → one `tx_start` pulse, `tx_data`=0xA5, `grant`=0100. A `tx_done` pulse 50 cycles later → `ack`=0100 for one cycle, `busy` low 2 cycles after `tx_done`.
- Contention: `req`=1111 from reset with bytes 0x10/0x21/0x32/0x43 → transmissions 0x10, 0x21, 0x32, 0x43 in order. A re-raised `req[0]` is served next, via wrap-around.
- Fairness: `req[3]` held continuously and `req[1]` raised during the 3's transfer → 3, 1, 3 sequence. `req[3]` is never starved and never served twice while 1 is waiting.
- Timeout: TIMEOUT_CYCLES=100, `tx_done` never asserted → `err[k]` pulses 100 cycles after `tx_start`, `ack` stays 0, `ptr` advances. The next request is granted normally.
- Races: `tx_done` arriving on the timeout cycle → `ack` only. A `tx_done` pulse in IDLE → no output change. `req_data` modified during WAIT → `tx_data` unchanged.
- Reset mid-WAIT: `arstn`=0 for 3 cycles → all outputs 0, no `ack`/`err`. After release, `req`=0010 is granted with `ptr` restarted at 0. Run end-to-end with a real `uart_tx` at CLK_FREQ=50e6, BAUD_RATE=9600 and a UART RX checker decoding the bytes.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Request/grant bundle and the uart_tx-side handshake shared by uart_tx_arbiter and its neighbours.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            err;
    logic                          busy;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_done;

    modport master (
        input  req, req_data, tx_done,
        output grant, ack, err, busy, tx_start, tx_data
    );

    modport slave (
        output req, req_data, tx_done,
        input  grant, ack, err, busy, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Each grant ends in exactly one ack or err pulse; a watchdog bounds the wait for tx_done.
//
// state | meaning
// IDLE  | no transfer in flight; arbitrate among requesters
// WAIT  | byte handed to uart_tx; waiting for tx_done or watchdog expiry
// DONE  | ack/err pulse cycle; release grant and advance the round-robin pointer
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              arstn,
    uart_tx_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      win_q, win_d;
    logic [PTR_W-1:0]      pick, cand;
    logic                  found;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [NUM_REQ-1:0]    err_q, err_d;
    logic [NUM_REQ-1:0]    pick_oh, win_oh;
    logic                  busy_q, busy_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, pick_data;

    // Search starts at ptr and wraps at NUM_REQ-1, which also covers non-power-of-two NUM_REQ.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        cand      = ptr_q;
        pick_data = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == PTR_W'(i)) begin
                pick_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign pick_oh = NUM_REQ'(1) << pick;
    assign win_oh  = NUM_REQ'(1) << win_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        timer_d    = timer_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        err_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = WAIT;
                    win_d      = pick;
                    grant_d    = pick_oh;
                    tx_data_d  = pick_data;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    timer_d    = '0;
                end
            end
            WAIT: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
                // tx_done takes priority over a watchdog expiry in the same cycle
                if (bus.tx_done) begin
                    ack_d   = win_oh;
                    state_d = DONE;
                end else if (timer_q == TMR_LIMIT) begin
                    err_d   = win_oh;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            timer_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            timer_q    <= timer_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transmitter model answers each tx_start and queues the expected outcome,
// a monitor pops and compares on every ack/err. Directed scenarios first, then randomized traffic.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 100;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    typedef struct {
        int       idx;
        logic [7:0] data;
        bit       is_err;
        int       lat;
        int       start;
    } exp_t;

    exp_t       sb_q[$];
    int         served_q[$];
    bit         kind_q[$];
    logic [7:0] data_log[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int ptr_m   = 0;

    logic [N-1:0]    req_prev;
    logic [N*DW-1:0] data_prev;
    bit              rand_en   = 1'b0;
    bit              resp_rand = 1'b0;
    int              resp_fix  = 20;
    logic [N-1:0]    hold      = '0;
    bit              ts_prev   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping around.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int off = 0; off < N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [N*DW-1:0] v, input int i);
        return 8'(v >> (i * DW));
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        req_prev  <= bus.req;
        data_prev <= bus.req_data;
    end

    // Transmitter model: picks a completion delay per transfer and records the expected outcome.
    initial begin : responder
        exp_t e;
        int   d;
        bit   aborted;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (arstn && bus.tx_start) begin
                e.idx = rr_pick(req_prev, ptr_m);
                chk("start_has_req", (e.idx >= 0), 1);
                if (e.idx >= 0) ptr_m = (e.idx + 1) % N;
                e.data   = (e.idx >= 0) ? byte_of(data_prev, e.idx) : 8'h00;
                d        = resp_rand ? $urandom_range(1, 130) : resp_fix;
                e.is_err = (d > T - 1);
                e.lat    = e.is_err ? T : d + 1;
                e.start  = cyc;
                sb_q.push_back(e);
                if (!e.is_err) begin
                    aborted = 1'b0;
                    for (int k = 0; k < d; k++) begin
                        @(posedge clk);
                        if (!arstn) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    if (!aborted) begin
                        #1 bus.tx_done = 1'b1;
                        @(posedge clk);
                        #1 bus.tx_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                ts_prev = 1'b0;
            end else begin
                if (bus.tx_start) begin
                    chk("start_single_cycle", ts_prev, 0);
                    chk("busy_at_start", bus.busy, 1);
                    chk("grant_onehot_start", $onehot(bus.grant), 1);
                end
                ts_prev = bus.tx_start;
                if ((bus.ack | bus.err) != '0) begin
                    chk("resp_onehot", $onehot(bus.ack | bus.err), 1);
                    chk("resp_expected", (sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e  = sb_q.pop_front();
                        oh = N'(1) << e.idx;
                        chk("ack_bits", bus.ack, e.is_err ? '0 : oh);
                        chk("err_bits", bus.err, e.is_err ? oh : '0);
                        chk("resp_latency", cyc - e.start, e.lat);
                        chk("tx_data_held", bus.tx_data, e.data);
                        chk("grant_at_resp", bus.grant, oh);
                        served_q.push_back(e.idx);
                        kind_q.push_back(e.is_err);
                        data_log.push_back(bus.tx_data);
                    end
                end
            end
        end
    end

    // Requesters: drop req on the edge after ack/err; optionally raise new requests at random.
    initial begin : driver
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if ((bus.ack[i] | bus.err[i]) && !hold[i]) begin
                    bus.req[i] = 1'b0;
                end else if (rand_en && !bus.req[i] && $urandom_range(0, 7) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[i*DW +: DW] = 8'($urandom);
                end else if (rand_en && bus.grant[i] && $urandom_range(0, 7) == 0) begin
                    bus.req_data[i*DW +: DW] = 8'($urandom);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        arstn       = 1'b0;
        bus.req     = '0;
        bus.tx_done = 1'b0;
        hold        = '0;
        sb_q.delete();
        ptr_m = 0;
        @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_ack_err", {bus.ack, bus.err}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
    endtask

    task automatic wait_start(input string nm, input int budget);
        int k = 0;
        @(negedge clk);
        while (!bus.tx_start && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, bus.tx_start, 1);
    endtask

    task automatic wait_served(input string nm, input int target, input int budget);
        int k = 0;
        while (served_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, (served_q.size() >= target), 1);
    endtask

    initial begin : main
        int         base;
        int         k;
        logic [7:0] cont_b[4];
        int         fair_exp[3];
        cont_b   = '{8'h10, 8'h21, 8'h32, 8'h43};
        fair_exp = '{3, 1, 3};
        bus.req      = '0;
        bus.req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single request, completion after 50 cycles
        resp_fix = 50;
        bus.req_data[2*DW +: DW] = 8'hA5;
        bus.req = 4'b0100;
        wait_start("single_start", 20);
        chk("single_grant", bus.grant, 4'b0100);
        chk("single_tx_data", bus.tx_data, 8'hA5);
        @(negedge clk);
        chk("single_start_low", bus.tx_start, 0);
        k = 0;
        while (bus.ack == '0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("single_ack", bus.ack, 4'b0100);
        @(negedge clk);
        chk("single_ack_pulse", bus.ack, 0);
        chk("single_busy_low", bus.busy, 0);

        // contention from reset, then wrap-around back to requester 0
        @(posedge clk);
        #1 do_reset();
        resp_fix     = 20;
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        base         = served_q.size();
        bus.req      = 4'b1111;
        wait_served("cont_wait", base + 4, 400);
        if (served_q.size() >= base + 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("cont_order", served_q[base+j], j);
                chk("cont_data", data_log[base+j], cont_b[j]);
            end
        end
        @(posedge clk);
        #1;
        bus.req_data[0 +: DW] = 8'h5A;
        bus.req[0] = 1'b1;
        wait_served("wrap_wait", base + 5, 200);
        if (served_q.size() >= base + 5) chk("wrap_idx", served_q[base+4], 0);

        // fairness: 3 held continuously, 1 raised during 3's transfer
        @(posedge clk);
        #1 do_reset();
        hold = 4'b1000;
        bus.req_data[3*DW +: DW] = 8'h33;
        bus.req_data[1*DW +: DW] = 8'h11;
        base    = served_q.size();
        bus.req = 4'b1000;
        wait_start("fair_start", 20);
        @(posedge clk);
        #1 bus.req[1] = 1'b1;
        wait_served("fair_wait", base + 3, 300);
        if (served_q.size() >= base + 3) begin
            for (int j = 0; j < 3; j++) chk("fair_order", served_q[base+j], fair_exp[j]);
        end

        // timeout on requester 0, then the pointer has moved past it
        @(posedge clk);
        #1 do_reset();
        resp_fix = 1000;
        bus.req_data[0 +: DW] = 8'h0E;
        base    = served_q.size();
        bus.req = 4'b0001;
        wait_served("tmo_wait", base + 1, 300);
        if (served_q.size() >= base + 1) begin
            chk("tmo_idx", served_q[base], 0);
            chk("tmo_is_err", kind_q[base], 1);
        end
        resp_fix = 30;
        @(posedge clk);
        #1;
        bus.req_data[0 +: DW]  = 8'h01;
        bus.req_data[DW +: DW] = 8'h02;
        bus.req = 4'b0011;
        wait_served("post_tmo_wait", base + 3, 300);
        if (served_q.size() >= base + 3) begin
            chk("post_tmo_first", served_q[base+1], 1);
            chk("post_tmo_second", served_q[base+2], 0);
            chk("post_tmo_kind", kind_q[base+1], 0);
        end

        // tx_done on the watchdog cycle: ack wins
        resp_fix = T - 1;
        @(posedge clk);
        #1;
        bus.req_data[2*DW +: DW] = 8'h77;
        base    = served_q.size();
        bus.req = 4'b0100;
        wait_served("race_wait", base + 1, 300);
        if (served_q.size() >= base + 1) begin
            chk("race_idx", served_q[base], 2);
            chk("race_is_ack", kind_q[base], 0);
        end

        // stray tx_done while idle
        repeat (3) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("idle_done_outputs", {bus.grant, bus.ack, bus.err, bus.busy, bus.tx_start}, 0);
            chk("idle_done_tx_data", bus.tx_data, 8'h77);
        end

        // req_data rewritten during WAIT is not picked up
        resp_fix = 40;
        @(posedge clk);
        #1;
        bus.req_data[DW +: DW] = 8'h3C;
        base    = served_q.size();
        bus.req = 4'b0010;
        wait_start("hold_start", 20);
        repeat (5) @(posedge clk);
        #1 bus.req_data[DW +: DW] = 8'hC3;
        @(negedge clk);
        chk("hold_tx_data", bus.tx_data, 8'h3C);
        wait_served("hold_wait", base + 1, 200);

        // reset in the middle of WAIT drops the transfer and restarts the pointer
        resp_fix = 1000;
        @(posedge clk);
        #1 bus.req = 4'b0100;
        wait_start("rstw_start", 20);
        repeat (10) @(posedge clk);
        #1 do_reset();
        resp_fix = 20;
        bus.req_data[DW +: DW]   = 8'h99;
        bus.req_data[2*DW +: DW] = 8'h98;
        base    = served_q.size();
        bus.req = 4'b0110;
        wait_start("rstw_regrant", 20);
        chk("rstw_grant", bus.grant, 4'b0010);
        wait_served("rstw_wait", base + 1, 200);

        // randomized traffic
        @(posedge clk);
        #1 do_reset();
        resp_rand = 1'b1;
        rand_en   = 1'b1;
        base      = served_q.size();
        wait_served("rand_wait", base + 150, 40000);
        rand_en = 1'b0;
        k = 0;
        while ((bus.req != '0 || bus.busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rand_drain", {bus.req, bus.busy}, 0);
        repeat (4) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
